seg_display_scanner: RTL and testbench
======================================

# seg_display_scanner

Time-multiplexed driver for a common-cathode multi-digit 7-segment display. It sits directly upstream of the hex-to-7-segment decoder and, on every scan slot, presents that decoder with one 4-bit character code. It also drives the matching one-hot digit enable. It holds a committed display image, which is either a hex value or a canned PASS/FAIL/dash message, and updates that image only at frame boundaries so the display never tears.

## Interface
- `NUM_DIGITS`, default 4: number of scanned digits; must be ≥ 4.
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; must be ≥ 2.
- `BLINK_FRAMES`, default 32: frames per blink half-period. Used only with `SCAN_BLINK_EN`.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `value_in` in 4*NUM_DIGITS: hex image; nibble k drives digit k, and digit 0 is the rightmost.
- `mode_in` in 2: display mode. 0 = VALUE, 1 = PASS, 2 = FAIL, 3 = DASH.
- `load` in 1: single-cycle strobe that captures `value_in` and `mode_in`.
- `hex_out` out 4: character code fed to the decoder.
- `digit_en` out NUM_DIGITS: one-hot, active-high enable for the digit currently shown.
- `frame_tick` out 1: one-cycle pulse on the edge where the scan wraps to digit 0.
- `pending` out 1: high while a captured load has not yet been committed.

## Operation
- **Prescaler:** counts 0..REFRESH_DIV-1. The cycle at terminal count is `scan_tick`, after which the count returns to 0.
- **Scan index:** advances on each `scan_tick` and wraps from NUM_DIGITS-1 to 0. The wrap edge is the frame boundary; `frame_tick` is asserted for that one cycle.
- **Load capture:**
  - `load` captures `value_in` and `mode_in` into shadow registers and sets `pending`.
  - If a second `load` arrives before commit, it overwrites the shadow. Last write wins.
- **Commit:**
  - On a frame boundary with `pending` set, shadow moves to the active image and `pending` clears.
  - If `load` coincides with a frame boundary, `value_in`/`mode_in` are committed directly on that edge and `pending` stays 0.
- **Character selection for digit k:**
  - VALUE: active nibble k.
  - PASS: digits 3..0 = B, A, C, C (P A S S).
  - FAIL: digits 3..0 = D, A, 1, E (F A I L).
  - DASH: every digit = F.
  - Digits ≥ 4 show F in every message mode.
- **Registered outputs:** `hex_out` and `digit_en` are registered and update together on the `scan_tick` edge, so no cycle ever pairs a new enable with a stale code.

## Timing
- **Reset values:**
  - Prescaler = 0; scan index = NUM_DIGITS-1.
  - `hex_out` = 0, `digit_en` = 0, `frame_tick` = 0, `pending` = 0.
  - Active and shadow images = 0; mode = VALUE.
  - Blink phase = on; frame counter = 0.
- **First enable:** the first `scan_tick` after reset occurs REFRESH_DIV cycles after reset release. On that edge the index wraps to 0, `digit_en` becomes 1, and `frame_tick` pulses.
- **Slot length:** each digit stays enabled for exactly REFRESH_DIV cycles. A frame is NUM_DIGITS × REFRESH_DIV cycles.
- **Load latency:** a `load` reaches `hex_out` no earlier than the next frame boundary and no later than one frame plus one cycle after the strobe.
- **Reset mid-frame:** all state returns to reset values immediately; any pending load is discarded.
- **Inputs outside a strobe:** `value_in` and `mode_in` are ignored whenever `load` = 0.

## Configuration
- **Macro:** `SCAN_BLINK_EN`.
- **With the macro defined:**
  - A frame counter toggles the blink phase every BLINK_FRAMES frame boundaries.
  - While the active mode is FAIL and the phase is off, `digit_en` is forced to 0. The scan still advances and `frame_tick` is unaffected.
  - A commit into a new mode resets the phase to on and clears the frame counter.
- **Without the macro:** the frame counter and phase logic are absent, and FAIL displays steadily like every other mode.

## Structure
- **Shared package `seg_display_pkg`:**
  - Mode encodings: MODE_VALUE, MODE_PASS, MODE_FAIL, MODE_DASH.
  - Character codes consumed by the decoder: CH_A = A, CH_P = B, CH_S = C, CH_F = D, CH_L = E, CH_DASH = F, CH_I = 1.
- **Sub-module `scan_prescaler`:** the REFRESH_DIV counter producing `scan_tick`. It is reused later for the debouncer.

## Test plan
All scenarios use REFRESH_DIV = 4 and NUM_DIGITS = 4; blink scenarios also use BLINK_FRAMES = 2.

- **Reset release:** `digit_en` = 0 for 4 cycles, then 0001 with `frame_tick` = 1, then 0010 four cycles later; the pattern repeats with a 16-cycle period.
- **Value load:** VALUE load of 16'h1234 mid-frame → `pending` = 1 until the next wrap. From that wrap, `hex_out` = 4, 3, 2, 1 on `digit_en` 0001, 0010, 0100, 1000.
- **Load on frame boundary:** `load` asserted on the wrap cycle → committed on that edge, `pending` never rises, and digit 0 shows the new nibble immediately.
- **Back-to-back loads:** two loads in one frame (PASS, then FAIL) → the next frame shows D, A, 1, E on digits 3..0.
- **Reset mid-operation:** `rst` pulse while `pending` = 1 → all outputs return to 0, and after release the display shows 0000 in VALUE mode.
- **Blink, `SCAN_BLINK_EN` defined:** FAIL committed → `digit_en` active for 2 frames, all-zero for 2 frames, repeating; `frame_tick` keeps its 16-cycle period throughout.

Source files
------------

// File: rtl/seg_display_scanner_pkg.sv
// Shared definitions for the 7-segment scanner: display modes, decoder
// character codes and the canned-message character lookup.
package seg_display_pkg;

  typedef enum logic [1:0] {
    MODE_VALUE = 2'd0,
    MODE_PASS  = 2'd1,
    MODE_FAIL  = 2'd2,
    MODE_DASH  = 2'd3
  } mode_e;

  // Codes understood by the downstream hex-to-7-segment decoder
  localparam logic [3:0] CH_A    = 4'hA;
  localparam logic [3:0] CH_P    = 4'hB;
  localparam logic [3:0] CH_S    = 4'hC;
  localparam logic [3:0] CH_F    = 4'hD;
  localparam logic [3:0] CH_L    = 4'hE;
  localparam logic [3:0] CH_DASH = 4'hF;
  localparam logic [3:0] CH_I    = 4'h1;

  // Character for digit position 'digit' in a message mode; positions past
  // the four-letter words are padded with dashes.
  function automatic logic [3:0] msg_char(input mode_e mode, input int unsigned digit);
    logic [3:0] ch;
    ch = CH_DASH;
    if (digit < 4) begin
      case (mode)
        MODE_PASS: begin
          case (digit)
            3:       ch = CH_P;
            2:       ch = CH_A;
            default: ch = CH_S;
          endcase
        end
        MODE_FAIL: begin
          case (digit)
            3:       ch = CH_F;
            2:       ch = CH_A;
            1:       ch = CH_I;
            default: ch = CH_L;
          endcase
        end
        default: ch = CH_DASH;
      endcase
    end
    return ch;
  endfunction

endpackage

// File: rtl/seg_display_scanner_if.sv
// Load/display bundle between a controller (master) and the scanner (slave).
interface seg_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [1:0]              mode_in;
  logic                    load;
  logic [3:0]              hex_out;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_tick;
  logic                    pending;

  modport master (
    output value_in, mode_in, load,
    input  hex_out, digit_en, frame_tick, pending
  );

  modport slave (
    input  value_in, mode_in, load,
    output hex_out, digit_en, frame_tick, pending
  );
endinterface

// File: rtl/seg_display_scanner_prescaler.sv
// Free-running divider: counts 0..DIV-1 and flags the terminal-count cycle.
// Kept generic so the debouncer can reuse it.
module scan_prescaler #(
  parameter int unsigned DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == TERM);

  // Wrap to zero right after the terminal-count cycle
  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed common-cathode 7-segment scanner. Holds a committed
// display image (hex value or canned message) and swaps it only at frame
// boundaries so a frame never mixes old and new content.
// Optional feature macro: SCAN_BLINK_EN (blinks the display while in FAIL).
module seg_display_scanner
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 32
) (
  input logic                  clk,
  input logic                  rst,
  seg_display_scanner_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 4) begin : g_chk_digits
    $error("seg_display_scanner: NUM_DIGITS must be at least 4");
  end
  if (REFRESH_DIV < 2) begin : g_chk_div
    $error("seg_display_scanner: REFRESH_DIV must be at least 2");
  end
  if (BLINK_FRAMES < 1) begin : g_chk_blink
    $error("seg_display_scanner: BLINK_FRAMES must be at least 1");
  end

  logic                    scan_tick;
  logic                    wrap;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d;
  logic [4*NUM_DIGITS-1:0] shd_val_q, shd_val_d;
  mode_e                   act_mode_q, act_mode_d;
  mode_e                   shd_mode_q, shd_mode_d;
  logic                    pending_q, pending_d;
  logic [3:0]              hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    frame_q;
  logic                    blank;

  scan_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .tick_o (scan_tick)
  );

  // The frame boundary is the scan tick that wraps the index back to digit 0
  assign wrap = scan_tick && (idx_q == LAST_IDX);

  // Scan index advance
  always_comb begin
    idx_d = idx_q;
    if (scan_tick) idx_d = wrap ? '0 : idx_q + 1'b1;
  end

  // Shadow capture and frame-boundary commit; a load on the boundary itself
  // bypasses the shadow so it is shown without waiting a whole extra frame
  always_comb begin
    act_val_d  = act_val_q;
    act_mode_d = act_mode_q;
    shd_val_d  = shd_val_q;
    shd_mode_d = shd_mode_q;
    pending_d  = pending_q;
    if (bus.load) begin
      shd_val_d  = bus.value_in;
      shd_mode_d = mode_e'(bus.mode_in);
      if (wrap) begin
        act_val_d  = bus.value_in;
        act_mode_d = mode_e'(bus.mode_in);
        pending_d  = 1'b0;
      end else begin
        pending_d  = 1'b1;
      end
    end else if (wrap && pending_q) begin
      act_val_d  = shd_val_q;
      act_mode_d = shd_mode_q;
      pending_d  = 1'b0;
    end
  end

`ifdef SCAN_BLINK_EN
  localparam int FCNT_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              phase_q, phase_d;

  // Blink phase: restarts "on" whenever the committed mode changes
  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (act_mode_d != act_mode_q) begin
      fcnt_d  = '0;
      phase_d = 1'b1;
    end else if (wrap) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d  = fcnt_q + 1'b1;
      end
    end
  end

  // Blink state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q  <= '0;
      phase_q <= 1'b1;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blank = (act_mode_d == MODE_FAIL) && !phase_d;
`else
  assign blank = 1'b0;
`endif

  // Next code/enable pair, computed from the post-commit image so the
  // boundary edge already shows new content on digit 0
  always_comb begin
    hex_d = hex_q;
    en_d  = en_q;
    if (scan_tick) begin
      if (act_mode_d == MODE_VALUE) hex_d = 4'(act_val_d >> (4 * idx_d));
      else                          hex_d = msg_char(act_mode_d, 32'(idx_d));
      en_d = blank ? '0 : ({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d);
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= LAST_IDX;
      act_val_q  <= '0;
      act_mode_q <= MODE_VALUE;
      shd_val_q  <= '0;
      shd_mode_q <= MODE_VALUE;
      pending_q  <= 1'b0;
      hex_q      <= '0;
      en_q       <= '0;
      frame_q    <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      act_val_q  <= act_val_d;
      act_mode_q <= act_mode_d;
      shd_val_q  <= shd_val_d;
      shd_mode_q <= shd_mode_d;
      pending_q  <= pending_d;
      hex_q      <= hex_d;
      en_q       <= en_d;
      frame_q    <= wrap;
    end
  end

  assign bus.hex_out    = hex_q;
  assign bus.digit_en   = en_q;
  assign bus.frame_tick = frame_q;
  assign bus.pending    = pending_q;
endmodule

// File: tb/tb_seg_display_scanner.sv
module tb_seg_display_scanner;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_display_scanner_if #(.NUM_DIGITS(ND)) bus ();

  seg_display_scanner #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] hex;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [3:0] exp_char(input int mode, input logic [15:0] v, input int k);
    logic [3:0] c;
    case (mode)
      0: c = v[4*k +: 4];
      1: case (k) 3: c = 4'hB; 2: c = 4'hA; default: c = 4'hC; endcase
      2: case (k) 3: c = 4'hD; 2: c = 4'hA; 1: c = 4'h1; default: c = 4'hE; endcase
      default: c = 4'hF;
    endcase
    return c;
  endfunction

  task automatic push_frame(input int mode, input logic [15:0] v);
    exp_t e;
    for (int k = 0; k < ND; k++) begin
      e.en  = 4'(1 << k);
      e.hex = exp_char(mode, v, k);
      sb.push_back(e);
    end
  endtask

  task automatic wait_frame(output int cycles);
    cycles = 0;
    while (bus.frame_tick !== 1'b1 && cycles < 40) begin
      step();
      cycles++;
    end
    chk("frame_found", 32'(bus.frame_tick), 32'h1);
  endtask

  task automatic check_frame(input string tag);
    exp_t e;
    for (int k = 0; k < ND; k++) begin
      chk({tag, "_sb_avail"}, 32'(sb.size() > 0), 32'h1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, "_en"}, 32'(bus.digit_en), 32'(e.en));
        chk({tag, "_hex"}, 32'(bus.hex_out), 32'(e.hex));
      end
      chk({tag, "_ftick"}, 32'(bus.frame_tick), 32'(k == 0));
      step(RD);
    end
  endtask

  initial begin
    int c;
    bus.load     = 1'b0;
    bus.value_in = '0;
    bus.mode_in  = 2'd0;

    step(2);
    chk("rst_hex", 32'(bus.hex_out), 32'h0);
    chk("rst_en", 32'(bus.digit_en), 32'h0);
    chk("rst_ftick", 32'(bus.frame_tick), 32'h0);
    chk("rst_pending", 32'(bus.pending), 32'h0);

    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i < RD; i++) begin
      step();
      chk("rel_idle_en", 32'(bus.digit_en), 32'h0);
    end
    step();
    chk("rel_first_en", 32'(bus.digit_en), 32'h1);
    chk("rel_first_ftick", 32'(bus.frame_tick), 32'h1);
    chk("rel_first_hex", 32'(bus.hex_out), 32'h0);
    step();
    chk("rel_ftick_pulse", 32'(bus.frame_tick), 32'h0);
    chk("rel_slot_hold", 32'(bus.digit_en), 32'h1);
    step(RD - 1);
    chk("rel_second_en", 32'(bus.digit_en), 32'h2);

    // mid-frame VALUE load, then garbage on the inputs without a strobe
    bus.load = 1'b1; bus.value_in = 16'h1234; bus.mode_in = 2'd0;
    step();
    bus.load = 1'b0; bus.value_in = 16'hFFFF; bus.mode_in = 2'd3;
    chk("val_pending_set", 32'(bus.pending), 32'h1);
    push_frame(0, 16'h1234);
    step(3);
    chk("val_pending_hold", 32'(bus.pending), 32'h1);
    wait_frame(c);
    chk("val_pending_clr", 32'(bus.pending), 32'h0);
    check_frame("val");
    chk("frame_period", 32'(bus.frame_tick), 32'h1);

    // load on the wrap cycle commits directly
    step(4 * RD - 1);
    chk("bnd_pre_pending", 32'(bus.pending), 32'h0);
    bus.load = 1'b1; bus.value_in = 16'hABCD; bus.mode_in = 2'd0;
    push_frame(0, 16'hABCD);
    step();
    bus.load = 1'b0;
    chk("bnd_pending", 32'(bus.pending), 32'h0);
    check_frame("bnd");
    chk("bnd_pending_after", 32'(bus.pending), 32'h0);

    // two loads in one frame: last write wins
    step(2);
    bus.load = 1'b1; bus.value_in = 16'h0000; bus.mode_in = 2'd1;
    step();
    bus.load = 1'b0;
    step(3);
    bus.load = 1'b1; bus.value_in = 16'h9999; bus.mode_in = 2'd2;
    step();
    bus.load = 1'b0;
    chk("b2b_pending", 32'(bus.pending), 32'h1);
    push_frame(2, 16'h0000);
    wait_frame(c);
    check_frame("b2b");

    // reset while a load is pending
    step(3);
    bus.load = 1'b1; bus.value_in = 16'h5678; bus.mode_in = 2'd0;
    step();
    bus.load = 1'b0;
    chk("mid_pending", 32'(bus.pending), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_hex", 32'(bus.hex_out), 32'h0);
    chk("mid_rst_en", 32'(bus.digit_en), 32'h0);
    chk("mid_rst_pending", 32'(bus.pending), 32'h0);
    chk("mid_rst_ftick", 32'(bus.frame_tick), 32'h0);
    step(2);
    rst = 1'b0;
    push_frame(0, 16'h0000);
    wait_frame(c);
    chk("mid_rel_latency", 32'(c), 32'(RD));
    check_frame("after_rst");

`ifdef SCAN_BLINK_EN
    step(5);
    bus.load = 1'b1; bus.value_in = 16'h0000; bus.mode_in = 2'd2;
    step();
    bus.load = 1'b0;
    wait_frame(c);
    for (int f = 0; f < 2 * BF; f++) begin
      for (int k = 0; k < ND; k++) begin
        chk("blink_en", 32'(bus.digit_en), 32'((f < BF) ? (1 << k) : 0));
        chk("blink_ftick", 32'(bus.frame_tick), 32'(k == 0));
        step(RD);
      end
    end
    chk("blink_reon_en", 32'(bus.digit_en), 32'h1);
`endif

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
